// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   In-order instruction fetch unit. Issues word-address requests to an
//   instruction memory, collects the in-order responses into a small queue and
//   presents the queue head, with its PC, to a consumer. A branch/jump
//   redirect flushes the queue, restarts fetching at the new PC and marks every
//   still-outstanding request so that its response is thrown away.
//
// Parameters
//   IW       instruction width
//   AW       PC width (word address)
//   DEPTH    queue entries (power of 2, >= 2)
//   RESET_PC PC after reset
//
// Ports
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_start                            one-cycle pulse, IDLE -> RUN
//   o_imem_req/o_imem_addr/i_imem_gnt  request channel
//   i_imem_rvalid/i_imem_rdata         in-order response channel
//   i_redirect/i_redirect_pc           taken branch/jump
//   o_inst_valid/o_inst_data/o_inst_pc queue head
//   i_inst_ready                       consumer pops the head
//   o_busy                             requests outstanding
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned   IW       = 32,
   parameter int unsigned   AW       = 32,
   parameter int unsigned   DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   output logic          o_imem_req,
   output logic [AW-1:0] o_imem_addr,
   input  logic          i_imem_gnt,
   input  logic          i_imem_rvalid,
   input  logic [IW-1:0] i_imem_rdata,
   input  logic          i_redirect,
   input  logic [AW-1:0] i_redirect_pc,
   output logic          o_inst_valid,
   output logic [IW-1:0] o_inst_data,
   output logic [AW-1:0] o_inst_pc,
   input  logic          i_inst_ready,
   output logic          o_busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   // Counters must reach DEPTH itself, hence one extra bit.
   localparam int unsigned CW = PW + 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_fpc;          // next address to request
   logic [AW-1:0] r_rpc;          // PC of the next kept response
   logic [CW-1:0] r_inflight;     // granted, response not yet returned
   logic [CW-1:0] r_drop;         // outstanding responses to discard
   logic [PW:0]   r_wptr, r_rptr; // queue pointers with wrap bit

   logic [IW-1:0] r_qdata [DEPTH];
   logic [AW-1:0] r_qpc   [DEPTH];

   logic [PW:0]   w_occ;
   logic [CW:0]   w_load;
   logic          w_credit_ok;
   logic          w_full;
   logic          w_gnt;
   logic          w_dropping;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_inflight_nxt;

   // --------------------------------------------------------------------------
   // Credit: every granted request owns a queue slot until it is popped (or
   // flushed), so queue occupancy plus outstanding requests never exceeds
   // DEPTH. Requests destined to be dropped still hold credit until their
   // response returns, which keeps the count simple and safe.
   // --------------------------------------------------------------------------
   assign w_occ       = r_wptr - r_rptr;
   assign w_load      = {1'b0, w_occ} + {1'b0, r_inflight};
   assign w_credit_ok = (w_load < (CW+1)'(DEPTH));
   assign w_full      = (w_occ == CW'(DEPTH));

   // --------------------------------------------------------------------------
   // FSM: next state and request output
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_imem_req  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // The credit term can only shrink via a grant, so once raised the
            // request holds (with a stable address) until granted or redirected.
            o_imem_req = !i_redirect && w_credit_ok;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_imem_addr = r_fpc;

   // --------------------------------------------------------------------------
   // Datapath control
   // --------------------------------------------------------------------------
   assign w_gnt          = o_imem_req && i_imem_gnt;
   assign w_dropping     = i_imem_rvalid && (r_drop != '0);
   // A redirect flushes the queue, so neither a response nor a pop in the same
   // cycle may touch it.
   assign w_push         = i_imem_rvalid && !w_dropping && !i_redirect;
   assign w_pop          = o_inst_valid && i_inst_ready && !i_redirect;
   assign w_inflight_nxt = r_inflight + CW'(w_gnt) - CW'(i_imem_rvalid);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fpc      <= RESET_PC;
         r_rpc      <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (i_redirect) begin
            r_fpc  <= i_redirect_pc;
            r_rpc  <= i_redirect_pc;
            // Every request still outstanding after this cycle (older drops
            // included) belongs to the abandoned path.
            r_drop <= w_inflight_nxt;
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_gnt)      r_fpc  <= r_fpc + AW'(1);
            if (w_dropping) r_drop <= r_drop - CW'(1);
            if (w_push) begin
               r_wptr <= r_wptr + (PW+1)'(1);
               r_rpc  <= r_rpc + AW'(1);
            end
            if (w_pop)      r_rptr <= r_rptr + (PW+1)'(1);
         end
      end
   end

   // Queue storage needs no reset; validity comes from the pointers.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_qdata[r_wptr[PW-1:0]] <= i_imem_rdata;
         r_qpc[r_wptr[PW-1:0]]   <= r_rpc;
      end
   end

   // Head is read straight from storage: a pushed entry shows up the cycle
   // after its response, never combinationally.
   assign o_inst_valid = (r_wptr != r_rptr);
   assign o_inst_data  = r_qdata[r_rptr[PW-1:0]];
   assign o_inst_pc    = r_qpc[r_rptr[PW-1:0]];
   assign o_busy       = (r_inflight != '0);

   // --------------------------------------------------------------------------
   // Protocol checks
   // --------------------------------------------------------------------------
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_imem_rvalid && (r_drop == '0) && w_full));

   a_no_spurious_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_imem_rvalid && (r_inflight == '0)));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   localparam int IW = 32, AW = 32, DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start, i_imem_gnt, i_imem_rvalid, i_redirect, i_inst_ready;
   logic [IW-1:0] i_imem_rdata;
   logic [AW-1:0] i_redirect_pc;
   logic          o_imem_req, o_inst_valid, o_busy;
   logic [AW-1:0] o_imem_addr, o_inst_pc;
   logic [IW-1:0] o_inst_data;

   always #5 clk = ~clk;

   inst_fetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_inst_valid(o_inst_valid), .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc),
      .i_inst_ready(i_inst_ready), .o_busy(o_busy));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: a fetch stream is the run of consecutive PCs starting at
   // the last redirect target; responses are tagged with the path (epoch) they
   // were requested on and only current-path responses enter the queue.
   typedef struct {logic [31:0] a; int ep;} req_t;
   req_t        pend[$];
   logic [31:0] mq[$];
   logic [31:0] obs_acc[$], obs_pop[$];
   bit          run;
   logic [31:0] efpc;
   int          epoch;
   int          gnt_pct, rv_pct, rdy_pct;

   task automatic model_reset();
      pend.delete(); mq.delete(); run = 0; efpc = '0; epoch++;
   endtask

   task automatic tick();
      bit          exp_req, acc, pop, rv, redir, st;
      logic [31:0] rpc;
      #1;
      exp_req = run && !i_redirect && (mq.size() + pend.size() < DEPTH);
      chk("req", o_imem_req, exp_req);
      if (exp_req) chk("addr", o_imem_addr, efpc);
      chk("valid", o_inst_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("head_pc", o_inst_pc, mq[0]);
         chk("head_data", o_inst_data, memf(mq[0]));
      end
      chk("busy", o_busy, pend.size() != 0);
      acc   = exp_req && i_imem_gnt;
      pop   = (mq.size() != 0) && i_inst_ready;
      rv    = i_imem_rvalid;
      redir = i_redirect;
      rpc   = i_redirect_pc;
      st    = i_start;
      if (o_imem_req && i_imem_gnt) obs_acc.push_back(o_imem_addr);
      if (o_inst_valid && i_inst_ready) obs_pop.push_back(o_inst_pc);
      @(posedge clk); #1;
      if (pop) void'(mq.pop_front());
      if (rv) begin
         req_t r;
         r = pend.pop_front();
         if (r.ep == epoch && !redir) mq.push_back(r.a);
      end
      if (redir) begin mq.delete(); epoch++; efpc = rpc; end
      if (st) run = 1;
      if (acc) begin pend.push_back('{efpc, epoch}); efpc = efpc + 1; end
   endtask

   task automatic cyc();
      i_imem_gnt    = ($urandom_range(99) < gnt_pct);
      i_imem_rvalid = (pend.size() != 0) && ($urandom_range(99) < rv_pct);
      i_imem_rdata  = i_imem_rvalid ? memf(pend[0].a) : $urandom();
      i_inst_ready  = ($urandom_range(99) < rdy_pct);
      tick();
      i_start = 0; i_redirect = 0; i_redirect_pc = $urandom();
   endtask

   task automatic knobs(input int g, input int r, input int d);
      gnt_pct = g; rv_pct = r; rdy_pct = d;
   endtask

   task automatic drain();
      knobs(0, 100, 100);
      for (int i = 0; i < 30 && (pend.size() != 0 || mq.size() != 0); i++) cyc();
      chk("drain_busy", o_busy, 0);
      chk("drain_valid", o_inst_valid, 0);
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      i_redirect = 1; i_redirect_pc = pc; cyc();
   endtask

   initial begin
      int n0;
      logic [31:0] a0;
      rst_n = 0; i_start = 0; i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
      i_redirect = 0; i_redirect_pc = '0; i_inst_ready = 0;
      epoch = 0; model_reset(); knobs(0, 0, 0);
      #12;
      chk("rst_req", o_imem_req, 0);
      chk("rst_valid", o_inst_valid, 0);
      chk("rst_busy", o_busy, 0);
      #10 rst_n = 1;
      @(posedge clk); #1;

      // Streaming: one instruction per cycle, PCs 0,1,2...
      knobs(100, 100, 100); obs_pop.delete();
      cyc(); cyc();
      i_start = 1; cyc();
      repeat (10) cyc();
      n0 = obs_pop.size();
      repeat (10) cyc();
      chk("stream_rate", obs_pop.size() - n0, 10);
      for (int i = 0; i < 8; i++) chk("stream_pc", obs_pop[i], i);

      // Back-pressure: exactly DEPTH grants, then request drops, then resumes.
      drain();
      knobs(100, 100, 0); obs_acc.delete();
      repeat (10) cyc();
      chk("bp_grants", obs_acc.size(), DEPTH);
      chk("bp_req_low", o_imem_req, 0);
      knobs(100, 100, 100);
      repeat (4) cyc();
      chk("bp_resume", obs_acc.size() > DEPTH, 1);

      // Three inflight at 5,6,7 then redirect to 0x40.
      drain();
      knobs(100, 0, 100); obs_acc.delete();
      redirect_to(32'd5);
      repeat (3) cyc();
      chk("inf_a0", obs_acc[0], 5);
      chk("inf_a1", obs_acc[1], 6);
      chk("inf_a2", obs_acc[2], 7);
      knobs(0, 0, 100); obs_pop.delete();
      redirect_to(32'h40);
      knobs(100, 100, 100);
      repeat (12) cyc();
      chk("redir_first_pc", obs_pop[0], 32'h40);
      drain();

      // Grant withheld: request and address hold.
      knobs(0, 100, 100);
      cyc();
      a0 = o_imem_addr;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_req", o_imem_req, 1);
         chk("hold_addr", o_imem_addr, a0);
      end

      // Wrap at 2^AW-1, then redirect colliding with rvalid and pop.
      knobs(100, 100, 100); obs_acc.delete();
      redirect_to(32'hFFFF_FFFF);
      repeat (6) cyc();
      chk("wrap_a0", obs_acc[0], 32'hFFFF_FFFF);
      chk("wrap_a1", obs_acc[1], 32'h0);
      redirect_to(32'h100);
      chk("coll_empty", o_inst_valid, 0);
      repeat (6) cyc();

      // Reset with 2 inflight and queue half full.
      drain();
      knobs(100, 0, 0); repeat (2) cyc();
      knobs(0, 100, 0); repeat (2) cyc();
      knobs(100, 0, 0); repeat (2) cyc();
      i_imem_gnt = 0; i_imem_rvalid = 0; i_inst_ready = 0;
      #3 rst_n = 0;
      #1;
      chk("mid_rst_req", o_imem_req, 0);
      chk("mid_rst_valid", o_inst_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      knobs(100, 100, 100); obs_acc.delete();
      cyc();
      i_start = 1; cyc();
      repeat (4) cyc();
      chk("restart_pc", obs_acc[0], 0);

      // Randomized traffic.
      for (int w = 0; w < 30; w++) begin
         knobs($urandom_range(100), $urandom_range(100), $urandom_range(100));
         for (int c = 0; c < 50; c++) begin
            if ($urandom_range(99) < 3) begin
               i_redirect = 1;
               i_redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom();
            end
            if ($urandom_range(99) < 2) i_start = 1;
            cyc();
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters SHALL be: IW, 32, instruction width; AW, 32, PC width (word address); DEPTH, 4, queue entries (power of 2, >=2); RESET_PC, 0, PC after reset.
REQ-002 Ports SHALL be, in order: i_clk  in  1  clock; i_rst_n  in  1  asynchronous active-low reset.
REQ-003 i_start  in  1  one-cycle pulse that starts fetching.
REQ-004 o_imem_req  out  1  fetch request; o_imem_addr  out  AW  request word address; i_imem_gnt  in  1  request accepted this cycle.
REQ-005 i_imem_rvalid  in  1  response valid; i_imem_rdata  in  IW  response data; responses return in request order, at least 1 cycle after gnt.
REQ-006 i_redirect  in  1  branch/jump taken; i_redirect_pc  in  AW  new fetch PC.
REQ-007 o_inst_valid  out  1  queue head valid; o_inst_data  out  IW  head instruction; o_inst_pc  out  AW  head PC; i_inst_ready  in  1  consumer pops head.
REQ-008 o_busy  out  1  inflight counter non-zero.

Function
REQ-009 Two states SHALL exist: IDLE (no requests) and RUN; IDLE->RUN on i_start; no return to IDLE except by reset.
REQ-010 Fetch PC fpc SHALL start at RESET_PC; o_imem_addr = fpc.
REQ-011 o_imem_req SHALL be high iff state==RUN, i_redirect==0, and occupancy+inflight < DEPTH.
REQ-012 Once high, o_imem_req SHALL stay high with o_imem_addr stable until i_imem_gnt, unless i_redirect.
REQ-013 On req&gnt: fpc <= fpc+1 (mod 2^AW, wrap silently), inflight +1.
REQ-014 On rvalid: inflight -1; if drop>0 then discard response, drop -1; else push {rpc, rdata} to queue and rpc <= rpc+1.
REQ-015 rpc SHALL track the PC of the next non-dropped response; reset value RESET_PC.
REQ-016 Pushed entry SHALL appear at o_inst_* the cycle after rvalid (no bypass); minimum gnt-to-o_inst_valid latency 2 cycles.
REQ-017 o_inst_valid = queue non-empty; pop on o_inst_valid & i_inst_ready; push and pop in the same cycle SHALL both take effect.
REQ-018 Credit rule SHALL make queue overflow impossible; rvalid with queue full and drop==0 is a protocol error (assertion).
REQ-019 On i_redirect (any state): queue emptied, fpc <= i_redirect_pc, rpc <= i_redirect_pc, drop <= inflight after this cycle's rvalid decrement; a pop or rvalid in the same cycle SHALL NOT write the queue.
REQ-020 Redirect while drop>0 SHALL set drop to all currently outstanding requests (older drops included).
REQ-021 Consecutive redirects SHALL each take effect; last one wins.
REQ-022 i_start while RUN SHALL be ignored; i_start and i_redirect in the same cycle: enter RUN at i_redirect_pc.
REQ-023 o_inst_data/o_inst_pc SHALL be don't-care when o_inst_valid==0.

Reset
REQ-024 On i_rst_n low, asynchronously: state IDLE, fpc=rpc=RESET_PC, inflight=drop=0, queue empty; o_imem_req=0, o_inst_valid=0, o_busy=0.
REQ-025 Reset mid-operation SHALL abandon outstanding requests; the bench keeps memory quiet during reset.

Verification
REQ-026 Reset, i_start, gnt every cycle, rvalid 1 cycle later, ready=1 -> PCs 0,1,2,... on o_inst_pc, one per cycle, data matches memory.
REQ-027 i_inst_ready=0, DEPTH=4 -> exactly 4 grants, then o_imem_req low; raise ready -> req resumes after first pop, no entry lost.
REQ-028 3 requests inflight (addr 5,6,7), redirect to 0x40 -> those 3 responses dropped, first o_inst_pc=0x40, o_busy low after drain.
REQ-029 Hold gnt=0 for 5 cycles -> o_imem_req and o_imem_addr stable all 5 cycles.
REQ-030 Redirect to 2^AW-1 -> fetches 2^AW-1 then 0; redirect in same cycle as rvalid and pop -> queue empty next cycle.
REQ-031 Assert reset with 2 inflight and queue half full -> all outputs reset values immediately; after i_start, fetch restarts at RESET_PC.
